ili_rd_ctrl: RTL and testbench
==============================

// Module: ili_rd_ctrl
// PURPOSE
// Host-side SPI read engine for the ILI9341 (4-wire serial, DCX line): the read direction of the panel interface.
// Issues one command byte, optionally clocks one dummy bit, then shifts in 1..4 response bytes from SDO.
// Sits beside the command/pixel write path after power-up reset completes; the write path and this block share the pins through an external mux.
// Used for ID/status reads (0x04, 0x09, 0xDA..0xDC).
// PARAMETERS
// CLK_DIV       2  clk cycles per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
// CS_SETUP_CYC  1  clk cycles CSX low before first SCK rise phase (>=1)
// CS_HOLD_CYC   1  clk cycles after last SCK fall before CSX returns high (>=1)
// MAX_BYTES     4  max response bytes; sets o_rd_data width to 8*MAX_BYTES
// PORTS
// clk          in   1              system clock
// rst          in   1              synchronous reset, active-high
// i_rd_req     in   1              start request; sampled only when o_busy=0
// i_rd_cmd     in   8              command byte, sent MSB first
// i_rd_nbytes  in   3              response bytes; 0 -> 1, >MAX_BYTES -> MAX_BYTES
// i_rd_dummy   in   1              1: insert one dummy SCK period after command
// i_spi_miso   in   1              panel SDO
// o_spi_csx    out  1              chip select, active-low
// o_spi_dcx    out  1              0 during command byte, 1 otherwise
// o_spi_sck    out  1              serial clock, idles low
// o_spi_mosi   out  1              panel SDA (host-driven)
// o_rd_data    out  8*MAX_BYTES    response, right-justified, first byte most significant
// o_rd_valid   out  1              one-cycle pulse; o_rd_data valid that cycle and held until next accept
// o_busy       out  1              high from accept through o_rd_valid cycle
// BEHAVIOUR
// - Reset values: csx=1, dcx=1, sck=0, mosi=0, rd_data=0, rd_valid=0, busy=0; state=IDLE. All outputs registered.
// - rst is synchronous and wins over every transition; asserting it mid-transfer aborts: CSX high and SCK low on the next edge, no o_rd_valid.
// - FSM: IDLE -> SETUP -> CMD -> [DUMMY] -> DATA -> HOLD -> DONE -> IDLE.
//   - IDLE:  i_rd_req=1 latches cmd, clamped nbytes, and dummy; next edge csx=0, dcx=0, busy=1, mosi=cmd[7].
//   - SETUP: CS_SETUP_CYC cycles.
//   - CMD:   8 bits. MOSI changes only while SCK is low; SCK high for the 2nd half of each bit.
//   - DUMMY: one SCK period, dcx=1, mosi=0, MISO ignored.
//   - DATA:  8*N bits, dcx=1. MISO sampled on the clk edge where SCK goes 0->1; shifted in MSB first, left-shift into data register.
//   - HOLD:  SCK low; CS_HOLD_CYC cycles, then csx=1.
//   - DONE:  o_rd_valid=1 for exactly one cycle, busy still 1; next cycle IDLE.
// - Latency, accept edge to rd_valid cycle = 1 + CS_SETUP_CYC + 2*CLK_DIV*(8 + D + 8*N) + CS_HOLD_CYC.
//   Defaults, N=1, D=0: 67 cycles.
// - Unused upper bytes of o_rd_data are 0.
// - o_rd_data updates only at DONE; cleared at accept.
// - i_rd_req while busy is ignored, not queued. Req held high in the DONE cycle is not accepted until IDLE.
// - Back-to-back requests: minimum gap of one IDLE cycle with csx=1.
// - Bit/byte counters are sized by $clog2(8*MAX_BYTES+1). Divider counter wraps at CLK_DIV-1 and is reset at every state entry.
// STRUCTURE
// - pkg_ili9341 additions:
//   - rd_state_t enum {IDLE,SETUP,CMD,DUMMY,DATA,HOLD,DONE}
//   - command constants RDDID=8'h04, RDDST=8'h09, RDID1=8'hDA, RDID2=8'hDB, RDID3=8'hDC
//   - reuse HIGH/LOW/ON/OFF
// - Sub-module ili_sck_gen: divider with enable, outputs sck level plus one-cycle rise/fall strobes; reusable by the write path.
// - Top holds the FSM, shift registers, and counters.
// TESTING
// - Bench SPI slave model shifts its response on SCK falling edges. Check CSX/SCK/DCX timing against the latency formula.
// 1. Read 0xDA, N=1, D=0; slave returns 8'h00 -> mosi bits 11011010 with dcx=0; rd_data=32'h0000_0000; rd_valid at cycle 67.
// 2. Read 0x04, N=3, D=1; slave returns 00,93,41 -> rd_data=32'h0000_9341; latency 1+1+4*33+1 = 135.
// 3. Read 0x09, N=4, D=1; slave returns A5,5A,FF,01 -> rd_data=32'hA55A_FF01.
// 4. nbytes=0 and nbytes=7 -> 8 and 32 data SCK pulses respectively; sck pulse count checked.
// 5. rst pulsed mid-DATA -> next edge csx=1, sck=0, busy=0; no rd_valid; fresh request then completes normally.
// 6. i_rd_req held high continuously -> transfers separated by >=1 cycle of csx=1; req toggled while busy -> ignored.

Source files
------------

// File: rtl/ili_rd_ctrl_pkg.sv
// Shared types and constants for the ILI9341 SPI read path.
package ili_rd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    DUMMY,
    DATA,
    HOLD,
    DONE
  } rd_state_t;

  localparam logic [7:0] RDDID = 8'h04;
  localparam logic [7:0] RDDST = 8'h09;
  localparam logic [7:0] RDID1 = 8'hDA;
  localparam logic [7:0] RDID2 = 8'hDB;
  localparam logic [7:0] RDID3 = 8'hDC;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  // A request for zero bytes still reads one; anything above the limit saturates.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] req, input logic [2:0] max_bytes);
    if (req == 3'd0) return 3'd1;
    if (req > max_bytes) return max_bytes;
    return req;
  endfunction

endpackage

// File: rtl/ili_sck_gen.sv
// SPI serial clock divider: registered SCK level plus combinational strobes that
// flag the clk edge on which SCK is about to rise or fall. Shared with the write path.
module ili_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = en && (div_cnt == DW'(CLK_DIV - 1));
  assign sck_rise = wrap && !sck;
  assign sck_fall = wrap && sck;

  // Each SCK half-period starts low with a fresh count, so a bit is low-then-high.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/ili_rd_ctrl.sv
// ILI9341 4-wire SPI read engine: sends a command byte, optionally one dummy
// clock, then shifts in 1..MAX_BYTES response bytes from SDO, MSB first.
module ili_rd_ctrl
  import ili_rd_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP_CYC = 1,
  parameter int CS_HOLD_CYC  = 1,
  parameter int MAX_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_req,
  input  logic [7:0]             i_rd_cmd,
  input  logic [2:0]             i_rd_nbytes,
  input  logic                   i_rd_dummy,
  input  logic                   i_spi_miso,
  output logic                   o_spi_csx,
  output logic                   o_spi_dcx,
  output logic                   o_spi_sck,
  output logic                   o_spi_mosi,
  output logic [8*MAX_BYTES-1:0] o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_busy
);

  localparam int DATA_W  = 8 * MAX_BYTES;
  localparam int CNT_W   = $clog2(8 * MAX_BYTES + 1);
  localparam int CYC_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  rd_state_t          state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]   nbits, nbits_n;
  logic [CNT_W-1:0]   req_nbits;
  logic [CYC_W-1:0]   cyc_cnt, cyc_cnt_n;
  logic [6:0]         cmd_sh, cmd_sh_n;
  logic [DATA_W-1:0]  data_sh, data_sh_n;
  logic [DATA_W-1:0]  rd_data_n;
  logic               dummy, dummy_n;
  logic               csx_n, dcx_n, mosi_n, rd_valid_n, busy_n;
  logic               sck_en, sck_rise, sck_fall;

  assign req_nbits = CNT_W'({clamp_nbytes(i_rd_nbytes, 3'(MAX_BYTES)), 3'b000});
  assign sck_en    = (state == CMD) || (state == DUMMY) || (state == DATA);

  ili_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sck_en),
    .clr      (state_n != state),
    .sck      (o_spi_sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      nbits      <= '0;
      cyc_cnt    <= '0;
      cmd_sh     <= '0;
      data_sh    <= '0;
      dummy      <= 1'b0;
      o_spi_csx  <= HIGH;
      o_spi_dcx  <= HIGH;
      o_spi_mosi <= LOW;
      o_rd_data  <= '0;
      o_rd_valid <= OFF;
      o_busy     <= OFF;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      nbits      <= nbits_n;
      cyc_cnt    <= cyc_cnt_n;
      cmd_sh     <= cmd_sh_n;
      data_sh    <= data_sh_n;
      dummy      <= dummy_n;
      o_spi_csx  <= csx_n;
      o_spi_dcx  <= dcx_n;
      o_spi_mosi <= mosi_n;
      o_rd_data  <= rd_data_n;
      o_rd_valid <= rd_valid_n;
      o_busy     <= busy_n;
    end
  end

  // MOSI moves on SCK fall edges so it is stable across every rise.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    nbits_n    = nbits;
    cyc_cnt_n  = cyc_cnt;
    cmd_sh_n   = cmd_sh;
    data_sh_n  = data_sh;
    dummy_n    = dummy;
    csx_n      = o_spi_csx;
    dcx_n      = o_spi_dcx;
    mosi_n     = o_spi_mosi;
    rd_data_n  = o_rd_data;
    rd_valid_n = OFF;
    busy_n     = o_busy;

    case (state)
      IDLE: begin
        if (i_rd_req) begin
          state_n   = SETUP;
          cmd_sh_n  = i_rd_cmd[6:0];
          nbits_n   = req_nbits;
          dummy_n   = i_rd_dummy;
          bit_cnt_n = '0;
          cyc_cnt_n = '0;
          data_sh_n = '0;
          rd_data_n = '0;
          csx_n     = LOW;
          dcx_n     = LOW;
          mosi_n    = i_rd_cmd[7];
          busy_n    = ON;
        end
      end
      SETUP: begin
        if (cyc_cnt == CYC_W'(CS_SETUP_CYC - 1)) begin
          state_n   = CMD;
          cyc_cnt_n = '0;
        end else begin
          cyc_cnt_n = cyc_cnt + CYC_W'(1);
        end
      end
      CMD: begin
        if (sck_fall) begin
          if (bit_cnt == CNT_W'(7)) begin
            state_n   = dummy ? DUMMY : DATA;
            bit_cnt_n = '0;
            dcx_n     = HIGH;
            mosi_n    = LOW;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
            mosi_n    = cmd_sh[6];
            cmd_sh_n  = {cmd_sh[5:0], 1'b0};
          end
        end
      end
      DUMMY: begin
        if (sck_fall) state_n = DATA;
      end
      DATA: begin
        if (sck_rise) data_sh_n = {data_sh[DATA_W-2:0], i_spi_miso};
        if (sck_fall) begin
          if (bit_cnt == nbits - CNT_W'(1)) begin
            state_n   = HOLD;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cyc_cnt == CYC_W'(CS_HOLD_CYC - 1)) begin
          state_n    = DONE;
          cyc_cnt_n  = '0;
          csx_n      = HIGH;
          rd_valid_n = ON;
          rd_data_n  = data_sh;
        end else begin
          cyc_cnt_n = cyc_cnt + CYC_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = OFF;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ili_rd_ctrl.sv
// Directed bench for ili_rd_ctrl with a cycle-sampled SPI slave model that
// shifts its response out on SCK falling edges.
module tb_ili_rd_ctrl;
  import ili_rd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd_req = 1'b0;
  logic [7:0]  i_rd_cmd = 8'h00;
  logic [2:0]  i_rd_nbytes = 3'd1;
  logic        i_rd_dummy = 1'b0;
  logic        spi_miso;
  logic        o_spi_csx, o_spi_dcx, o_spi_sck, o_spi_mosi;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_busy;

  int checks = 0;
  int passes = 0;

  // Slave model configuration and observations
  logic [31:0] slave_resp = 32'h0;
  int          slave_nbits = 8;
  int          slave_d = 0;
  logic        prev_sck = 1'b0, prev_csx = 1'b1, prev_mosi = 1'b0;
  int          rise_cnt = 0, dcx1_rises = 0, cmd_dcx_err = 0, mosi_hi_err = 0;
  logic [7:0]  mosi_cap = 8'h00;
  int          valid_cnt = 0, csx_falls = 0, hi_run = 0, last_gap = 0;

  ili_rd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_rd_req    (i_rd_req),
    .i_rd_cmd    (i_rd_cmd),
    .i_rd_nbytes (i_rd_nbytes),
    .i_rd_dummy  (i_rd_dummy),
    .i_spi_miso  (spi_miso),
    .o_spi_csx   (o_spi_csx),
    .o_spi_dcx   (o_spi_dcx),
    .o_spi_sck   (o_spi_sck),
    .o_spi_mosi  (o_spi_mosi),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Slave model, sampled mid-cycle; drives the next response bit after each SCK fall.
  always @(negedge clk) begin
    int idx;
    if (o_rd_valid === 1'b1) valid_cnt++;
    if (o_spi_csx === 1'b1) hi_run++;
    if (prev_csx === 1'b1 && o_spi_csx === 1'b0) begin
      csx_falls++;
      last_gap = hi_run;
      rise_cnt = 0;
      dcx1_rises = 0;
      cmd_dcx_err = 0;
      mosi_hi_err = 0;
      mosi_cap = 8'h00;
    end
    if (o_spi_csx === 1'b0) hi_run = 0;
    if (o_spi_csx === 1'b0 && prev_sck === 1'b0 && o_spi_sck === 1'b1) begin
      rise_cnt++;
      if (rise_cnt <= 8) begin
        mosi_cap = {mosi_cap[6:0], o_spi_mosi};
        if (o_spi_dcx !== 1'b0) cmd_dcx_err++;
      end
      if (o_spi_dcx === 1'b1) dcx1_rises++;
    end
    if (o_spi_csx === 1'b0 && prev_sck === 1'b1 && o_spi_sck === 1'b1 && o_spi_mosi !== prev_mosi)
      mosi_hi_err++;
    if (o_spi_csx !== 1'b0) begin
      spi_miso = 1'b0;
    end else if (prev_sck === 1'b1 && o_spi_sck === 1'b0) begin
      idx = rise_cnt - 8 - slave_d;
      if (idx >= 0 && idx < slave_nbits) spi_miso = slave_resp[slave_nbits - 1 - idx];
      else spi_miso = 1'b0;
    end
    prev_sck  = o_spi_sck;
    prev_csx  = o_spi_csx;
    prev_mosi = o_spi_mosi;
  end

  task automatic start_read(input logic [7:0] c, input logic [2:0] n, input logic d,
                            input logic [31:0] resp, input int nbits, output logic [3:0] acc);
    slave_resp = resp;
    slave_nbits = nbits;
    slave_d = d ? 1 : 0;
    for (int k = 0; k < 500 && o_busy !== 1'b0; k++) begin
      @(posedge clk); #1;
    end
    i_rd_cmd = c;
    i_rd_nbytes = n;
    i_rd_dummy = d;
    i_rd_req = 1'b1;
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    acc = {o_spi_csx, o_spi_dcx, o_busy, o_spi_mosi};
  endtask

  task automatic wait_valid(output int lat, output logic timed_out);
    lat = 1;
    timed_out = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (o_rd_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_spi_csx, o_spi_dcx, o_spi_sck, o_spi_mosi, o_rd_valid, o_busy} !== 6'b110000)
      $display("[TB] FAIL reset_ctrl: got %b expected 110000",
               {o_spi_csx, o_spi_dcx, o_spi_sck, o_spi_mosi, o_rd_valid, o_busy});
    else passes++;
    checks++;
    if (o_rd_data !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 00000000", o_rd_data);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_id1();
    logic [3:0] acc; int lat; logic to;
    start_read(RDID1, 3'd1, 1'b0, 32'h00, 8, acc);
    checks++;
    if (acc !== 4'b0011) $display("[TB] FAIL id1_accept: got %b expected 0011", acc); else passes++;
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0) $display("[TB] FAIL id1_timeout: got %b expected 0", to); else passes++;
    checks++;
    if (lat !== 67) $display("[TB] FAIL id1_latency: got %0d expected 67", lat); else passes++;
    checks++;
    if (o_rd_data !== 32'h0) $display("[TB] FAIL id1_data: got %h expected 00000000", o_rd_data); else passes++;
    checks++;
    if ({o_busy, o_spi_csx} !== 2'b11) $display("[TB] FAIL id1_done_state: got %b expected 11", {o_busy, o_spi_csx}); else passes++;
    checks++;
    if (mosi_cap !== 8'hDA) $display("[TB] FAIL id1_mosi: got %h expected da", mosi_cap); else passes++;
    checks++;
    if (cmd_dcx_err !== 0 || mosi_hi_err !== 0)
      $display("[TB] FAIL id1_dcx_mosi_timing: got %0d/%0d errors expected 0/0", cmd_dcx_err, mosi_hi_err);
    else passes++;
    checks++;
    if (rise_cnt !== 16) $display("[TB] FAIL id1_sck_count: got %0d expected 16", rise_cnt); else passes++;
    @(posedge clk); #1;
    checks++;
    if ({o_rd_valid, o_busy, o_spi_csx} !== 3'b001)
      $display("[TB] FAIL id1_after_done: got %b expected 001", {o_rd_valid, o_busy, o_spi_csx});
    else passes++;
  endtask

  task automatic test_read_dummy();
    logic [3:0] acc; int lat; logic to;
    start_read(RDDID, 3'd3, 1'b1, 32'h0000_9341, 24, acc);
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 135) $display("[TB] FAIL rddid_latency: got %0d (timeout %b) expected 135", lat, to); else passes++;
    checks++;
    if (o_rd_data !== 32'h0000_9341) $display("[TB] FAIL rddid_data: got %h expected 00009341", o_rd_data); else passes++;
    checks++;
    if (mosi_cap !== 8'h04) $display("[TB] FAIL rddid_mosi: got %h expected 04", mosi_cap); else passes++;
    checks++;
    if (rise_cnt !== 33 || dcx1_rises !== 25)
      $display("[TB] FAIL rddid_sck_count: got %0d/%0d expected 33/25", rise_cnt, dcx1_rises);
    else passes++;

    start_read(RDDST, 3'd4, 1'b1, 32'hA55A_FF01, 32, acc);
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 167) $display("[TB] FAIL rddst_latency: got %0d (timeout %b) expected 167", lat, to); else passes++;
    checks++;
    if (o_rd_data !== 32'hA55A_FF01) $display("[TB] FAIL rddst_data: got %h expected a55aff01", o_rd_data); else passes++;
    checks++;
    if (rise_cnt !== 41) $display("[TB] FAIL rddst_sck_count: got %0d expected 41", rise_cnt); else passes++;
  endtask

  task automatic test_nbytes_clamp();
    logic [3:0] acc; int lat; logic to;
    start_read(RDID2, 3'd0, 1'b0, 32'h0000_00C3, 8, acc);
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 67) $display("[TB] FAIL nb0_latency: got %0d (timeout %b) expected 67", lat, to); else passes++;
    checks++;
    if (dcx1_rises !== 8) $display("[TB] FAIL nb0_data_pulses: got %0d expected 8", dcx1_rises); else passes++;
    checks++;
    if (o_rd_data !== 32'h0000_00C3) $display("[TB] FAIL nb0_data: got %h expected 000000c3", o_rd_data); else passes++;

    start_read(RDID3, 3'd7, 1'b0, 32'h1234_5678, 32, acc);
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 163) $display("[TB] FAIL nb7_latency: got %0d (timeout %b) expected 163", lat, to); else passes++;
    checks++;
    if (dcx1_rises !== 32) $display("[TB] FAIL nb7_data_pulses: got %0d expected 32", dcx1_rises); else passes++;
    checks++;
    if (o_rd_data !== 32'h1234_5678) $display("[TB] FAIL nb7_data: got %h expected 12345678", o_rd_data); else passes++;
  endtask

  task automatic test_reset_abort();
    logic [3:0] acc; int lat; logic to; int v0;
    start_read(RDDST, 3'd4, 1'b0, 32'hFFFF_FFFF, 32, acc);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if ({o_spi_csx, o_spi_dcx, o_busy} !== 3'b011)
      $display("[TB] FAIL abort_in_data: got %b expected 011", {o_spi_csx, o_spi_dcx, o_busy});
    else passes++;
    v0 = valid_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_spi_csx, o_spi_sck, o_busy, o_rd_valid} !== 4'b1000)
      $display("[TB] FAIL abort_outputs: got %b expected 1000", {o_spi_csx, o_spi_sck, o_busy, o_rd_valid});
    else passes++;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (valid_cnt !== v0) $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", valid_cnt - v0); else passes++;
    start_read(RDID1, 3'd2, 1'b0, 32'h0000_BEEF, 16, acc);
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 99) $display("[TB] FAIL abort_fresh_latency: got %0d (timeout %b) expected 99", lat, to); else passes++;
    checks++;
    if (o_rd_data !== 32'h0000_BEEF) $display("[TB] FAIL abort_fresh_data: got %h expected 0000beef", o_rd_data); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] acc; int lat; logic to; int v0; int f0;
    for (int k = 0; k < 500 && o_busy !== 1'b0; k++) begin
      @(posedge clk); #1;
    end
    v0 = valid_cnt;
    f0 = csx_falls;
    slave_resp = 32'h0000_005C;
    slave_nbits = 8;
    slave_d = 0;
    i_rd_cmd = RDID2;
    i_rd_nbytes = 3'd1;
    i_rd_dummy = 1'b0;
    i_rd_req = 1'b1;
    for (int k = 0; k < 400 && valid_cnt < v0 + 2; k++) begin
      @(posedge clk); #1;
    end
    i_rd_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (valid_cnt - v0 !== 2 || csx_falls - f0 !== 2)
      $display("[TB] FAIL b2b_count: got %0d valid/%0d csx falls expected 2/2", valid_cnt - v0, csx_falls - f0);
    else passes++;
    checks++;
    if (last_gap < 1) $display("[TB] FAIL b2b_csx_gap: got %0d expected at least 1", last_gap); else passes++;
    checks++;
    if (o_rd_data !== 32'h0000_005C) $display("[TB] FAIL b2b_data: got %h expected 0000005c", o_rd_data); else passes++;

    v0 = valid_cnt;
    f0 = csx_falls;
    start_read(RDID3, 3'd1, 1'b0, 32'h0000_003C, 8, acc);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      i_rd_req = k[0];
      @(posedge clk); #1;
    end
    i_rd_req = 1'b0;
    wait_valid(lat, to);
    checks++;
    if (to !== 1'b0 || o_rd_data !== 32'h0000_003C)
      $display("[TB] FAIL busy_req_data: got %h (timeout %b) expected 0000003c", o_rd_data, to);
    else passes++;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (valid_cnt - v0 !== 1 || csx_falls - f0 !== 1)
      $display("[TB] FAIL busy_req_ignored: got %0d valid/%0d csx falls expected 1/1", valid_cnt - v0, csx_falls - f0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_read_id1();
    test_read_dummy();
    test_nbytes_clamp();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
